// File: rtl/ay_core_param.sv
// AY-series accumulator core: parametrised fetch/decode/execute FSM around a 74181-style logic ALU.
// Defining AY_CORE_ARITH_EN adds the class-2 arithmetic ops (ADD/SUB/INC/DEC/DBL) and the cf update.
module ay_core_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic              zf,
  output logic              cf,
  output logic              halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_IMM    = 3'd2;
  localparam logic [2:0] S_REF    = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [7:0]        op_q, op_d;
  logic              zf_q, zf_d, cf_q, cf_d, halted_q, halted_d;

  logic [3:0]        cls, fn;
  logic              two_byte, xfer;
  logic [DATA_W-1:0] logic_res;

  assign cls = op_q[7:4];
  assign fn  = op_q[3:0];

  function automatic logic [DATA_W-1:0] alu_logic(input logic [3:0] f,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    case (f)
      4'h0:    alu_logic = a;
      4'h1:    alu_logic = a | b;
      4'h2:    alu_logic = a | ~b;
      4'h3:    alu_logic = '1;
      4'h4:    alu_logic = a & b;
      4'h5:    alu_logic = b;
      4'h6:    alu_logic = ~(a ^ b);
      4'h7:    alu_logic = ~a | b;
      4'h8:    alu_logic = a & ~b;
      4'h9:    alu_logic = a ^ b;
      4'hA:    alu_logic = ~b;
      4'hB:    alu_logic = ~(a & b);
      4'hC:    alu_logic = '0;
      4'hD:    alu_logic = ~a & b;
      4'hE:    alu_logic = ~(a | b);
      default: alu_logic = ~a;
    endcase
  endfunction

  // imm_q doubles as B: it holds the operand word, or the referenced word after a REF read
  assign logic_res = alu_logic(fn, acc_q, imm_q);

`ifdef AY_CORE_ARITH_EN
  logic              arith_en, arith_sub;
  logic [DATA_W-1:0] arith_b;
  logic [DATA_W:0]   arith_sum;

  // Subtraction is A + ~B + 1, so the carry-out is the "no borrow" flag directly
  always_comb begin
    arith_en  = 1'b1;
    arith_sub = 1'b0;
    arith_b   = imm_q;
    case (fn)
      4'h6: ;
      4'h9: arith_sub = 1'b1;
      4'hF: arith_b = DATA_W'(1);
      4'h0: begin arith_b = DATA_W'(1); arith_sub = 1'b1; end
      4'h3: arith_b = acc_q;
      default: arith_en = 1'b0;
    endcase
    arith_sum = {1'b0, acc_q} + {1'b0, (arith_sub ? ~arith_b : arith_b)}
              + (DATA_W+1)'(arith_sub);
  end
`endif

  always_comb begin
    two_byte = 1'b0;
    case (cls)
      4'h0:             two_byte = !(fn inside {4'h0, 4'h3, 4'hC, 4'hF});
      4'h1, 4'h3, 4'h4: two_byte = 1'b1;
`ifdef AY_CORE_ARITH_EN
      4'h2:             two_byte = (fn == 4'h6) || (fn == 4'h9);
`endif
      default: ;
    endcase
  end

  // Reset gates the request combinationally so an in-flight access drops immediately
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = pc_q;
    case (state_q)
      S_FETCH, S_IMM: mem_req = !RST;
      S_REF: begin
        mem_req  = !RST;
        mem_addr = imm_q[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  assign xfer = mem_req && mem_ack;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    imm_d    = imm_q;
    op_d     = op_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    halted_d = halted_q;
    case (state_q)
      S_FETCH: if (xfer) begin
        op_d    = mem_rdata[7:0];
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: state_d = two_byte ? S_IMM : S_EXEC;
      S_IMM: if (xfer) begin
        imm_d   = mem_rdata;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = (cls == 4'h1) ? S_REF : S_EXEC;
      end
      S_REF: if (xfer) begin
        imm_d   = mem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (cls)
          4'h0, 4'h1: if (fn != 4'h0) begin
            acc_d = logic_res;
            zf_d  = (logic_res == '0);
          end
`ifdef AY_CORE_ARITH_EN
          4'h2: if (arith_en) begin
            acc_d = arith_sum[DATA_W-1:0];
            zf_d  = (arith_sum[DATA_W-1:0] == '0);
            cf_d  = arith_sum[DATA_W];
          end
`endif
          4'h3: pc_d = imm_q[ADDR_W-1:0];
          4'h4: if (zf_q) pc_d = imm_q[ADDR_W-1:0];
          4'hF: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: ;
        endcase
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      acc_q    <= '0;
      imm_q    <= '0;
      op_q     <= '0;
      zf_q     <= 1'b1;
      cf_q     <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      imm_q    <= imm_d;
      op_q     <= op_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      halted_q <= halted_d;
    end
  end

  assign acc    = acc_q;
  assign pc     = pc_q;
  assign zf     = zf_q;
  assign cf     = cf_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_ay_core_param.sv
// Bench for ay_core_param: vector table, directed multi-cycle sequences and a random program
// checked against an instruction-level model of the AY ISA.
module tb_ay_core_param;

`ifdef AY_CORE_ARITH_EN
  localparam bit ARITH = 1'b1;
`else
  localparam bit ARITH = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       mem_req, mem_ack, zf, cf, halted;
  logic [7:0] mem_addr, mem_rdata, acc, pc;

  ay_core_param #(.DATA_W(8), .ADDR_W(8)) dut (
    .CLK(CLK), .RST(RST), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .acc(acc), .pc(pc), .zf(zf), .cf(cf), .halted(halted)
  );

  always #5 CLK = ~CLK;

  // memory responder with configurable wait states
  logic [7:0] mem [0:255];
  int  wait_fixed = 0;
  int  wait_rand  = 0;
  int  eff_wait;
  bit  use_rand = 0, ack_hold = 0, ack_force = 0;
  int  wcnt = 0;
  int  xfer_cnt = 0;

  always_comb eff_wait = use_rand ? wait_rand : wait_fixed;
  assign mem_ack   = ack_force | (mem_req & ~ack_hold & (wcnt >= eff_wait));
  assign mem_rdata = mem[mem_addr];

  always @(posedge CLK) begin
    if (RST || !mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (RST) xfer_cnt <= 0;
    else if (mem_req && mem_ack) xfer_cnt <= xfer_cnt + 1;
    if (mem_req && mem_ack) wait_rand <= int'($urandom_range(0, 2));
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // ---------------- reference model (instruction level) ----------------
  // two-input truth tables per fn, indexed by {a_bit,b_bit}
  int tt [16] = '{12, 14, 13, 15, 8, 10, 9, 11, 4, 6, 5, 7, 0, 2, 1, 3};
  logic [7:0] m_acc, m_pc;
  bit         m_zf, m_cf, m_halt;

  function automatic int logic_ref(input int f, input int a, input int b);
    int r = 0;
    for (int i = 0; i < 8; i++)
      r |= ((tt[f] >> (((a >> i) & 1) * 2 + ((b >> i) & 1))) & 1) << i;
    return r;
  endfunction

  task automatic model_reset();
    m_acc = 8'h00; m_pc = 8'h00; m_zf = 1'b1; m_cf = 1'b1; m_halt = 1'b0;
  endtask

  task automatic model_step(output int reads);
    int op, c, f, imm, b, s;
    bit two;
    op = int'(mem[m_pc]); m_pc = m_pc + 8'd1; reads = 1;
    c = op / 16; f = op % 16;
    two = (c == 0 && !(f == 0 || f == 3 || f == 12 || f == 15)) || c == 1 || c == 3 || c == 4
       || (ARITH && c == 2 && (f == 6 || f == 9));
    imm = 0;
    if (two) begin imm = int'(mem[m_pc]); m_pc = m_pc + 8'd1; reads++; end
    b = imm;
    if (c == 1) begin b = int'(mem[imm]); reads++; end
    if ((c == 0 || c == 1) && f != 0) begin
      m_acc = 8'(logic_ref(f, int'(m_acc), b));
      m_zf  = (m_acc == 8'h00);
    end else if (ARITH && c == 2 && (f == 6 || f == 9 || f == 15 || f == 0 || f == 3)) begin
      case (f)
        6:       begin s = int'(m_acc) + imm;  m_cf = (s > 255); end
        15:      begin s = int'(m_acc) + 1;    m_cf = (s > 255); end
        3:       begin s = 2 * int'(m_acc);    m_cf = (s > 255); end
        9:       begin m_cf = (int'(m_acc) >= imm); s = int'(m_acc) - imm + 256; end
        default: begin m_cf = (int'(m_acc) >= 1);   s = int'(m_acc) + 255; end
      endcase
      m_acc = 8'(s % 256);
      m_zf  = (m_acc == 8'h00);
    end else if (c == 3) m_pc = 8'(imm);
    else if (c == 4 && m_zf) m_pc = 8'(imm);
    else if (c == 15) m_halt = 1'b1;
  endtask

  // ---------------- helpers ----------------
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("reset_state", {mem_req, acc, pc, zf, cf, halted}, {1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0});
    RST = 1'b0;
  endtask

  // runs until `target` reads have completed and the next fetch (or halt) is visible
  task automatic run_to(input int target, output int cyc);
    bit pw = 1'b0;
    bit ok = 1'b0;
    logic [7:0] pa = 8'h00;
    cyc = 0;
    while (cyc < 300 && !ok) begin
      @(negedge CLK);
      cyc++;
      if (pw && mem_req) chk("addr_hold", mem_addr, pa);
      pw = mem_req && !mem_ack;
      pa = mem_addr;
      if (xfer_cnt == target && (mem_req || halted)) ok = 1'b1;
    end
    if (!ok) timeout("run_to");
  endtask

  typedef struct packed {
    logic [7:0] a, op, imm, acc;
    logic       zf, cf;
    logic [7:0] pc;
  } vec_t;
  vec_t vt[$];

  initial begin
    int cyc, rq, r, total, hc;
    vec_t v;

    // a, op, imm, expected acc, zf, cf, pc  (program: 05 a op imm F0)
    vt.push_back({8'h3C, 8'h01, 8'hC3, 8'hFF, 1'b0, 1'b1, 8'h05});
    vt.push_back({8'hF0, 8'h02, 8'h0F, 8'hF0, 1'b0, 1'b1, 8'h05});
    vt.push_back({8'h12, 8'h03, 8'hF0, 8'hFF, 1'b0, 1'b1, 8'h04});
    vt.push_back({8'h3C, 8'h04, 8'hC3, 8'h00, 1'b1, 1'b1, 8'h05});
    vt.push_back({8'hAA, 8'h06, 8'hAA, 8'hFF, 1'b0, 1'b1, 8'h05});
    vt.push_back({8'h0F, 8'h07, 8'h00, 8'hF0, 1'b0, 1'b1, 8'h05});
    vt.push_back({8'hFF, 8'h08, 8'h0F, 8'hF0, 1'b0, 1'b1, 8'h05});
    vt.push_back({8'h5A, 8'h09, 8'h5A, 8'h00, 1'b1, 1'b1, 8'h05});
    vt.push_back({8'h5A, 8'h0A, 8'h0F, 8'hF0, 1'b0, 1'b1, 8'h05});
    vt.push_back({8'hFF, 8'h0B, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h05});
    vt.push_back({8'h77, 8'h0C, 8'hF0, 8'h00, 1'b1, 1'b1, 8'h04});
    vt.push_back({8'h0F, 8'h0D, 8'hFF, 8'hF0, 1'b0, 1'b1, 8'h05});
    vt.push_back({8'h0F, 8'h0E, 8'hF0, 8'h00, 1'b1, 1'b1, 8'h05});
    vt.push_back({8'h0F, 8'h0F, 8'hF0, 8'hF0, 1'b0, 1'b1, 8'h04});
    vt.push_back({8'h5A, 8'h00, 8'hF0, 8'h5A, 1'b0, 1'b1, 8'h04});
    vt.push_back({8'h5A, 8'h11, 8'h10, 8'hFF, 1'b0, 1'b1, 8'h05});  // mem[0x10]=A5
    vt.push_back({8'h33, 8'h60, 8'hF0, 8'h33, 1'b0, 1'b1, 8'h04});
`ifdef AY_CORE_ARITH_EN
    vt.push_back({8'hFF, 8'h2F, 8'hF0, 8'h00, 1'b1, 1'b1, 8'h04});
    vt.push_back({8'h00, 8'h29, 8'h01, 8'hFF, 1'b0, 1'b0, 8'h05});
    vt.push_back({8'h80, 8'h26, 8'h80, 8'h00, 1'b1, 1'b1, 8'h05});
    vt.push_back({8'h05, 8'h20, 8'hF0, 8'h04, 1'b0, 1'b1, 8'h04});
    vt.push_back({8'h81, 8'h23, 8'hF0, 8'h02, 1'b0, 1'b1, 8'h04});
`else
    vt.push_back({8'hFF, 8'h2F, 8'hF0, 8'hFF, 1'b0, 1'b1, 8'h04});
    vt.push_back({8'h00, 8'h29, 8'h01, 8'hF0, 1'b0, 1'b1, 8'h06});
    vt.push_back({8'h80, 8'h26, 8'h80, 8'h80, 1'b0, 1'b1, 8'h05});
    vt.push_back({8'h05, 8'h20, 8'hF0, 8'h05, 1'b0, 1'b1, 8'h04});
    vt.push_back({8'h81, 8'h23, 8'hF0, 8'h81, 1'b0, 1'b1, 8'h04});
`endif

    // basic program, zero-wait
    clear_mem();
    mem[0] = 8'h05; mem[1] = 8'h3C; mem[2] = 8'h01; mem[3] = 8'hC3; mem[4] = 8'hF0;
    do_reset();
    run_to(2, cyc);
    chk("t1_cyc_imm1", 64'(cyc), 64'd4);
    chk("t1_acc1", {acc, zf}, {8'h3C, 1'b0});
    run_to(4, cyc);
    chk("t1_cyc_imm2", 64'(cyc), 64'd4);
    chk("t1_acc2", {acc, zf}, {8'hFF, 1'b0});
    run_to(5, cyc);
    chk("t1_cyc_hlt", 64'(cyc), 64'd3);
    chk("t1_halt", {halted, pc, acc, zf}, {1'b1, 8'h05, 8'hFF, 1'b0});
    rq = 0;
    repeat (10) begin @(negedge CLK); rq += int'(mem_req); end
    chk("t1_no_req_after_halt", 64'(rq), 64'd0);
    chk("t1_req_count", 64'(xfer_cnt), 64'd5);
    chk("t1_frozen", {acc, pc, halted}, {8'hFF, 8'h05, 1'b1});

    // reference read with 2 wait states on every access
    clear_mem();
    mem[0] = 8'h15; mem[1] = 8'h10; mem[8'h10] = 8'h00;
    wait_fixed = 2;
    do_reset();
    run_to(3, cyc);
    chk("t2_cyc_ref_wait", 64'(cyc), 64'd11);
    chk("t2_result", {acc, zf, pc}, {8'h00, 1'b1, 8'h02});
    wait_fixed = 0;

    // JZ taken / not taken
    clear_mem();
    mem[0] = 8'h40; mem[1] = 8'h20;
    do_reset();
    run_to(2, cyc);
    chk("t3_jz_taken", {pc, mem_addr}, {8'h20, 8'h20});
    clear_mem();
    mem[0] = 8'h05; mem[1] = 8'h01; mem[2] = 8'h40; mem[3] = 8'h20;
    do_reset();
    run_to(2, cyc);
    run_to(4, cyc);
    chk("t3_jz_fall", {pc, mem_addr, zf}, {8'h04, 8'h04, 1'b0});

    // JMP to top of memory then a NOP: pc wraps
    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'hFF; mem[8'hFF] = 8'h60;
    do_reset();
    run_to(2, cyc);
    chk("t4_jmp", 64'(pc), 64'hFF);
    run_to(3, cyc);
    chk("t4_wrap", {pc, mem_addr, 8'(cyc)}, {8'h00, 8'h00, 8'd3});

    // reset while a reference read is stalled
    clear_mem();
    mem[0] = 8'h05; mem[1] = 8'h3C; mem[2] = 8'h15; mem[3] = 8'h10; mem[8'h10] = 8'hC3;
    do_reset();
    hc = 0;
    while (xfer_cnt != 4 && hc < 100) begin @(negedge CLK); hc++; end
    ack_hold = 1'b1;
    if (hc >= 100) timeout("t5_reach_ref");
    chk("t5_ref_pending", {mem_req, mem_addr, acc}, {1'b1, 8'h10, 8'h3C});
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    ack_force = 1'b1;
    @(negedge CLK);
    chk("t5_rst_state", {mem_req, acc, pc, zf, cf, halted}, {1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0});
    RST = 1'b0;
    ack_force = 1'b0;
    ack_hold = 1'b0;
    #1;
    chk("t5_refetch0", {mem_req, mem_addr}, {1'b1, 8'h00});
    run_to(2, cyc);
    chk("t5_rerun", {acc, pc}, {8'h3C, 8'h02});

    // vector table
    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      clear_mem();
      mem[0] = 8'h05; mem[1] = v.a; mem[2] = v.op; mem[3] = v.imm; mem[4] = 8'hF0;
      mem[8'h10] = 8'hA5;
      do_reset();
      hc = 0;
      while (!halted && hc < 200) begin @(negedge CLK); hc++; end
      if (hc >= 200) timeout($sformatf("vec%0d_halt", i));
      chk($sformatf("vec%0d op=%0h", i, v.op), {acc, zf, cf, pc}, {v.acc, v.zf, v.cf, v.pc});
    end

    // random programs with random wait states vs the instruction-level model
    use_rand = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 256; i++) begin
        logic [7:0] bt;
        bt = 8'($urandom_range(0, 255));
        if (p == 0) bt[7:4] = 4'($urandom_range(0, 4));
        else if (bt[7:4] == 4'hF) bt[7:4] = 4'h1;
        mem[i] = bt;
      end
      do_reset();
      model_reset();
      total = 0;
      for (int k = 0; k < 150; k++) begin
        model_step(r);
        total += r;
        run_to(total, cyc);
        chk($sformatf("rnd%0d_%0d", p, k), {acc, pc, zf, cf}, {m_acc, m_pc, m_zf, m_cf});
      end
    end
    use_rand = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ay_core_param.md
# ay_core_param

Parametrised fetch/decode/execute core for the AY-series accumulator CPU, replacing the fixed 8-bit fetch + decode_exec pair. Data width and address width are parameters. An internal 74181-style ALU is used. Supported instructions: logic, arithmetic, immediate operands, reference (memory-operand) operands, jumps and halt. Memory is reached through a single req/ack read port, so the core tolerates wait states.

## Interface
- `DATA_W`, default 8: accumulator, ALU and memory word width; must be ≥ 8.
- `ADDR_W`, default 8: PC and memory address width; must be ≤ `DATA_W`.
- `CLK`  in  1  clock; all state changes on its rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `mem_req`  out  1  read request.
- `mem_addr`  out  `ADDR_W`  read address; valid while `mem_req`=1.
- `mem_ack`  in  1  read completes in any cycle where `mem_req`=1 and `mem_ack`=1.
- `mem_rdata`  in  `DATA_W`  read data; sampled only on a completing cycle.
- `acc`  out  `DATA_W`  accumulator.
- `pc`  out  `ADDR_W`  program counter.
- `zf`  out  1  zero flag.
- `cf`  out  1  carry flag.
- `halted`  out  1  core stopped by HLT.

## Operation
- **Opcode word:** bits [7:4] are the class and [3:0] are `fn`. Bits above 7 are ignored. The operand word is `imm`; addresses use `imm[ADDR_W-1:0]`.
- **Logic functions** (A=acc, B=operand), by `fn`:
  - 0 NOP (A)
  - 1 A|B
  - 2 A|~B
  - 3 all-ones
  - 4 A&B
  - 5 B
  - 6 ~(A^B)
  - 7 ~A|B
  - 8 A&~B
  - 9 A^B
  - A ~B
  - B ~(A&B)
  - C all-zero
  - D ~A&B
  - E ~(A|B)
  - F ~A
- **Class 0, logic immediate:**
  - `fn` ∈ {0,3,C,F} is a 1-byte instruction and uses no B.
  - All other `fn` are 2-byte instructions with B=`imm`.
- **Class 1, logic reference:** 2-byte instruction; B=`mem[imm]`, which takes one extra read.
- **Class 2, arithmetic** (only with `AY_CORE_ARITH_EN`):
  - 6 ADD: A+imm, 2-byte.
  - 9 SUB: A−imm, 2-byte.
  - F INC: A+1, 1-byte.
  - 0 DEC: A−1, 1-byte.
  - 3 DBL: A+A, 1-byte.
  - Any other `fn` is a 1-byte NOP.
- **Class 3, JMP:** 2-byte; `pc`←`imm`.
- **Class 4, JZ:** 2-byte; `pc`←`imm` if `zf`=1, else fall through.
- **Class F, HLT:** 1-byte; sets `halted`. It stays set until `RST`.
- **Other classes:** 1-byte NOP; no flag change.
- **Flags:**
  - `zf` is updated by every logic and arithmetic op except logic NOP; it is set when the result is 0.
  - `cf` is updated only by arithmetic ops. On ADD/INC/DBL it is the carry-out. On SUB/DEC it is 1 when no borrow occurred (A ≥ operand).
  - Arithmetic is modulo 2^`DATA_W`.
- **PC:** incremented on every completed opcode or imm read. It wraps from all-ones to 0. Reference reads do not increment it.
- **States and transitions:**
  - FETCH: `req`, addr=`pc`; on ack → DECODE.
  - DECODE: routes a 1-byte instruction to EXEC, otherwise to IMM.
  - IMM: `req`, addr=`pc`; on ack → REF (class 1) or EXEC.
  - REF: `req`, addr=`imm`; on ack → EXEC.
  - EXEC: writes acc, flags and pc; → FETCH, or → HALT for HLT.
  - HALT: absorbing state.
- **Registered outputs:** `acc`, `pc`, `zf`, `cf` and `halted` are registered.
- **Memory port:** `mem_req` and `mem_addr` are decoded from the state.

## Timing
- **Reset values:**
  - state=FETCH, `pc`=0, `acc`=0, `zf`=1, `cf`=1, `halted`=0, `mem_req`=0 during RST.
  - The first request is issued in the first cycle after `RST` falls.
- **Request rules:**
  - `mem_req` and `mem_addr` stay constant until ack.
  - `mem_ack` is legal in the same cycle `req` rises (zero-wait).
  - Ack while `req`=0 is ignored.
- **Zero-wait latency:**
  - 1-byte instruction: 3 cycles.
  - Immediate, JMP or JZ: 4 cycles.
  - Reference: 5 cycles.
  - Each wait cycle adds 1.
- **Result visibility:** results are visible the cycle after EXEC, which is also the cycle the next FETCH `req` rises.
- **`RST` mid-transaction:** the access is abandoned. `mem_req`=0 the cycle after the `RST` edge. Later acks are ignored. No register retains partial results.
- **HALT:** `mem_req`=0 permanently; acc, pc and flags are frozen.

## Configuration
- `AY_CORE_ARITH_EN` defined: class 2 is implemented as above, with the carry chain and `cf` update logic present.
- `AY_CORE_ARITH_EN` undefined:
  - Class 2 decodes as a 1-byte NOP, including `fn` 6 and 9; the following word is fetched as an opcode.
  - `cf` holds its reset value 1 forever.

## Test plan
- Reset, then program {0x05,0x3C, 0x01,0xC3, 0xF0} with zero-wait acks → `acc`=0x3C, then 0xFF. `zf`=0 throughout. `halted`=1 with `pc`=5. Exactly 5 requests, then `mem_req` stays 0.
- Class 1: {0x15,0x10, ...} with mem[0x10]=0x00, plus 2 wait cycles on every ack → `acc`=0x00, `zf`=1, `pc`=2. The instruction takes 11 cycles. `mem_addr` is held stable during the waits.
- With `AY_CORE_ARITH_EN`: acc=0xFF then 0x2F (INC) → `acc`=0x00, `zf`=1, `cf`=1. 0x29,0x01 (SUB) → `acc`=0xFF, `cf`=0. Without the macro the same stream leaves `acc` unchanged and `cf`=1.
- JZ/JMP:
  - `zf`=1, {0x40,0x20} → next fetch addr 0x20.
  - `zf`=0 → next fetch addr 2.
  - JMP to 0xFF followed by a 1-byte NOP → `pc` wraps to 0x00.
- Assert `RST` for one cycle while a REF read is waiting → `mem_req`=0 the next cycle and all outputs equal their reset values. A late ack is ignored. The next fetch goes to addr 0.
